// File: rtl/wash_cycle_timer.sv
// wash_cycle_timer
// Phase timer for the washing-machine controller. It decodes the active phase
// from the controller's actuator outputs and counts prescaled ticks in that
// phase. When the phase's duration expires, it raises that phase's done flag.
//
// Optional feature macro: WASH_TIMER_PAUSE_EN
//   defined   : pause freezes the prescaler and elapsed count.
//   undefined : the pause port is present but ignored.
//
// Ports
//   clk                  rising-edge clock
//   reset                synchronous, active-high reset
//   restart              timer restart from the controller
//   water_fill, agitator,
//   motor, pump, speed   controller actuator outputs (phase decode inputs)
//   pause                door open / hold request
//   tfill, twash, trinse,
//   tdrain, tspin        registered done flags, held until the next clear
//   busy                 combinational: timer counts on this cycle
//   elapsed              registered tick count of the current phase
//
// Handshake: none. Flags are levels. The controller reacts by changing its
// actuator outputs (a phase change clears the timer) or by pulsing restart.
module wash_cycle_timer #(
  parameter int PRESCALE = 1000,
  parameter int CNT_W    = 16,
  parameter int T_FILL   = 30,
  parameter int T_WASH   = 120,
  parameter int T_RINSE  = 60,
  parameter int T_DRAIN  = 20,
  parameter int T_SPIN   = 90
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             water_fill,
  input  logic             agitator,
  input  logic             motor,
  input  logic             pump,
  input  logic             speed,
  input  logic             pause,
  output logic             tfill,
  output logic             twash,
  output logic             trinse,
  output logic             tdrain,
  output logic             tspin,
  output logic             busy,
  output logic [CNT_W-1:0] elapsed
);

  // A prescaler of 1 still gets a 1-bit register. That bit stays at 0, so
  // every counting cycle is a tick.
  localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] EL_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] EL_MAX  = '1;

  // Bit positions in the flag vector.
  localparam int F_FILL  = 0;
  localparam int F_WASH  = 1;
  localparam int F_RINSE = 2;
  localparam int F_DRAIN = 3;
  localparam int F_SPIN  = 4;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_FILL,
    PH_WASH,
    PH_DRAIN,
    PH_SPIN
  } phase_t;

  phase_t           phase, phase_q, phase_d;
  logic [PS_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0] el_q, el_d;
  logic [4:0]       flag_q, flag_d;
  logic             wash_cnt_q, wash_cnt_d;

  logic             pause_eff;
  logic             clear;
  logic             phase_flag;
  logic             count_en;
  logic             done;
  logic [CNT_W-1:0] limit;

`ifdef WASH_TIMER_PAUSE_EN
  assign pause_eff = pause;
`else
  assign pause_eff = 1'b0;
  logic unused_pause;
  assign unused_pause = pause;
`endif

  // Phase decode. The first match wins, so a conflicting drain request
  // overrides fill.
  always_comb begin
    phase = PH_IDLE;
    if (pump)                            phase = PH_DRAIN;
    else if (water_fill)                 phase = PH_FILL;
    else if (motor && speed)             phase = PH_SPIN;
    else if (motor && agitator && !speed) phase = PH_WASH;
  end

  // Limit and own-flag lookup for the decoded phase. A WASH phase counts
  // against the rinse duration once the first wash has completed.
  always_comb begin
    limit      = '0;
    phase_flag = 1'b0;
    case (phase)
      PH_FILL: begin
        limit      = CNT_W'(T_FILL);
        phase_flag = flag_q[F_FILL];
      end
      PH_WASH: begin
        limit      = wash_cnt_q ? CNT_W'(T_RINSE) : CNT_W'(T_WASH);
        phase_flag = flag_q[F_WASH];
      end
      PH_DRAIN: begin
        limit      = CNT_W'(T_DRAIN);
        phase_flag = flag_q[F_DRAIN];
      end
      PH_SPIN: begin
        limit      = CNT_W'(T_SPIN);
        phase_flag = flag_q[F_SPIN];
      end
      default: begin
        limit      = '0;
        phase_flag = 1'b0;
      end
    endcase
  end

  assign clear    = reset || restart || (phase != phase_q);
  assign count_en = (phase != PH_IDLE) && !pause_eff && !phase_flag;
  assign busy     = count_en && !clear;

  always_comb begin
    phase_d    = phase;
    pre_d      = pre_q;
    el_d       = el_q;
    flag_d     = flag_q;
    wash_cnt_d = wash_cnt_q;
    done       = 1'b0;

    if (clear) begin
      pre_d  = '0;
      el_d   = '0;
      flag_d = '0;
      // Only a hard reset forgets which wash the machine is on.
      if (reset) begin
        phase_d    = PH_IDLE;
        wash_cnt_d = 1'b0;
      end
    end else if (count_en) begin
      if (limit == '0) begin
        done = 1'b1;
      end else if (pre_q == PS_LAST) begin
        pre_d = '0;
        if (el_q != EL_MAX) el_d = el_q + EL_ONE;
        if ((el_q + EL_ONE) == limit) done = 1'b1;
      end else begin
        pre_d = pre_q + PS_W'(1);
      end

      if (done) begin
        case (phase)
          PH_FILL:  flag_d[F_FILL] = 1'b1;
          PH_DRAIN: flag_d[F_DRAIN] = 1'b1;
          PH_SPIN: begin
            flag_d[F_SPIN] = 1'b1;
            wash_cnt_d     = 1'b0;
          end
          PH_WASH: begin
            flag_d[F_WASH] = 1'b1;
            if (wash_cnt_q) flag_d[F_RINSE] = 1'b1;
            else            wash_cnt_d      = 1'b1;
          end
          default: flag_d = flag_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    phase_q    <= phase_d;
    pre_q      <= pre_d;
    el_q       <= el_d;
    flag_q     <= flag_d;
    wash_cnt_q <= wash_cnt_d;
  end

  assign tfill   = flag_q[F_FILL];
  assign twash   = flag_q[F_WASH];
  assign trinse  = flag_q[F_RINSE];
  assign tdrain  = flag_q[F_DRAIN];
  assign tspin   = flag_q[F_SPIN];
  assign elapsed = el_q;

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Directed testbench for wash_cycle_timer. It uses PRESCALE=4, T_FILL=3,
// T_WASH=2, T_RINSE=1, T_DRAIN=2 and T_SPIN=2. Inputs change 1 time unit after
// a rising edge, and outputs are checked at that same point.
module tb_wash_cycle_timer;

  logic        clk = 1'b0;
  logic        reset, restart;
  logic        water_fill, agitator, motor, pump, speed, pause;
  logic        tfill, twash, trinse, tdrain, tspin, busy;
  logic [15:0] elapsed;

  int total  = 0;
  int passed = 0;

  wash_cycle_timer #(
    .PRESCALE(4), .CNT_W(16), .T_FILL(3), .T_WASH(2),
    .T_RINSE(1), .T_DRAIN(2), .T_SPIN(2)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .water_fill(water_fill), .agitator(agitator), .motor(motor),
    .pump(pump), .speed(speed), .pause(pause),
    .tfill(tfill), .twash(twash), .trinse(trinse),
    .tdrain(tdrain), .tspin(tspin), .busy(busy), .elapsed(elapsed)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; restart = 1'b0; pause = 1'b0;
    water_fill = 1'b0; agitator = 1'b0; motor = 1'b0; pump = 1'b0; speed = 1'b0;
    tick(2);
    total++;
    if ({tfill, twash, trinse, tdrain, tspin} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {tfill, twash, trinse, tdrain, tspin});
    else passed++;
    total++;
    if (elapsed !== 16'd0) $display("FAIL reset_elapsed: got %0d want 0", elapsed);
    else passed++;
    water_fill = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_fill;
    reset = 1'b0;
    tick(1);  // clear edge
    total++;
    if (busy !== 1'b1) $display("FAIL fill_busy: got %b want 1", busy);
    else passed++;
    tick(11);
    total++;
    if (tfill !== 1'b0 || elapsed !== 16'd2)
      $display("FAIL fill_early: got tfill=%b el=%0d want 0/2", tfill, elapsed);
    else passed++;
    tick(1);
    total++;
    if (tfill !== 1'b1 || elapsed !== 16'd3 || busy !== 1'b0)
      $display("FAIL fill_done: got tfill=%b el=%0d busy=%b want 1/3/0", tfill, elapsed, busy);
    else passed++;
  endtask

  task automatic test_restart;
    restart = 1'b1; tick(1); restart = 1'b0;
    total++;
    if (tfill !== 1'b0 || elapsed !== 16'd0)
      $display("FAIL restart_clear: got tfill=%b el=%0d want 0/0", tfill, elapsed);
    else passed++;
    tick(9);
    total++;
    if (elapsed !== 16'd2) $display("FAIL restart_mid: got el=%0d want 2", elapsed);
    else passed++;
    restart = 1'b1; tick(1); restart = 1'b0;
    total++;
    if (tfill !== 1'b0 || elapsed !== 16'd0)
      $display("FAIL restart_mid_clear: got tfill=%b el=%0d want 0/0", tfill, elapsed);
    else passed++;
    tick(11);
    total++;
    if (tfill !== 1'b0) $display("FAIL restart_early: got %b want 0", tfill);
    else passed++;
    tick(1);
    total++;
    if (tfill !== 1'b1) $display("FAIL restart_done: got %b want 1", tfill);
    else passed++;
  endtask

  task automatic test_restart_vs_done;
    restart = 1'b1; tick(1); restart = 1'b0;
    tick(11);
    restart = 1'b1; tick(1); restart = 1'b0;  // collides with the done edge
    total++;
    if (tfill !== 1'b0 || elapsed !== 16'd0)
      $display("FAIL restart_wins: got tfill=%b el=%0d want 0/0", tfill, elapsed);
    else passed++;
    tick(12);
    total++;
    if (tfill !== 1'b1) $display("FAIL restart_wins_after: got %b want 1", tfill);
    else passed++;
  endtask

  task automatic test_wash;
    water_fill = 1'b0; motor = 1'b1; agitator = 1'b1;
    tick(1);
    total++;
    if (tfill !== 1'b0) $display("FAIL wash_enter_clear: got tfill=%b want 0", tfill);
    else passed++;
    tick(7);
    total++;
    if (twash !== 1'b0) $display("FAIL wash1_early: got %b want 0", twash);
    else passed++;
    tick(1);
    total++;
    if (twash !== 1'b1 || trinse !== 1'b0 || elapsed !== 16'd2)
      $display("FAIL wash1_done: got tw=%b tr=%b el=%0d want 1/0/2", twash, trinse, elapsed);
    else passed++;
    motor = 1'b0; tick(1);
    total++;
    if (twash !== 1'b0 || busy !== 1'b0)
      $display("FAIL wash_idle: got tw=%b busy=%b want 0/0", twash, busy);
    else passed++;
    motor = 1'b1; tick(1);
    tick(3);
    total++;
    if (twash !== 1'b0) $display("FAIL wash2_early: got %b want 0", twash);
    else passed++;
    tick(1);
    total++;
    if (twash !== 1'b1 || trinse !== 1'b1 || elapsed !== 16'd1)
      $display("FAIL wash2_done: got tw=%b tr=%b el=%0d want 1/1/1", twash, trinse, elapsed);
    else passed++;
  endtask

  task automatic test_spin_pause;
    int rem;
    logic exp_busy;
    logic [15:0] exp_el;
`ifdef WASH_TIMER_PAUSE_EN
    rem = 6; exp_busy = 1'b0; exp_el = 16'd0;
`else
    rem = 1; exp_busy = 1'b1; exp_el = 16'd1;
`endif
    speed = 1'b1;
    tick(1);
    total++;
    if (twash !== 1'b0 || trinse !== 1'b0)
      $display("FAIL spin_clear: got tw=%b tr=%b want 0/0", twash, trinse);
    else passed++;
    tick(2);
    pause = 1'b1;
    #1;
    total++;
    if (busy !== exp_busy) $display("FAIL spin_pause_busy: got %b want %b", busy, exp_busy);
    else passed++;
    tick(5);
    pause = 1'b0;
    total++;
    if (tspin !== 1'b0 || elapsed !== exp_el)
      $display("FAIL spin_after_pause: got ts=%b el=%0d want 0/%0d", tspin, elapsed, exp_el);
    else passed++;
    tick(rem - 1);
    total++;
    if (tspin !== 1'b0) $display("FAIL spin_early: got %b want 0", tspin);
    else passed++;
    tick(1);
    total++;
    if (tspin !== 1'b1 || elapsed !== 16'd2)
      $display("FAIL spin_done: got ts=%b el=%0d want 1/2", tspin, elapsed);
    else passed++;
  endtask

  task automatic test_wash_after_spin;
    speed = 1'b0;
    tick(1);
    tick(7);
    total++;
    if (twash !== 1'b0) $display("FAIL post_spin_wash_early: got %b want 0", twash);
    else passed++;
    tick(1);
    total++;
    if (twash !== 1'b1 || trinse !== 1'b0)
      $display("FAIL post_spin_wash_done: got tw=%b tr=%b want 1/0", twash, trinse);
    else passed++;
  endtask

  task automatic test_conflict;
    motor = 1'b0; agitator = 1'b0; pump = 1'b1; water_fill = 1'b1;
    tick(1);
    tick(7);
    total++;
    if (tdrain !== 1'b0) $display("FAIL conflict_early: got %b want 0", tdrain);
    else passed++;
    tick(1);
    total++;
    if (tdrain !== 1'b1 || tfill !== 1'b0 || elapsed !== 16'd2)
      $display("FAIL conflict_done: got td=%b tf=%b el=%0d want 1/0/2", tdrain, tfill, elapsed);
    else passed++;
    tick(12);
    total++;
    if (tdrain !== 1'b1 || tfill !== 1'b0 || elapsed !== 16'd2)
      $display("FAIL conflict_hold: got td=%b tf=%b el=%0d want 1/0/2", tdrain, tfill, elapsed);
    else passed++;
  endtask

  task automatic test_switch;
    pump = 1'b0;  // FILL
    tick(1);
    tick(4);
    total++;
    if (elapsed !== 16'd1) $display("FAIL switch_fill_el: got %0d want 1", elapsed);
    else passed++;
    pump = 1'b1;  // DRAIN
    tick(1);
    total++;
    if (elapsed !== 16'd0 || tfill !== 1'b0 || tdrain !== 1'b0)
      $display("FAIL switch_clear: got el=%0d tf=%b td=%b want 0/0/0", elapsed, tfill, tdrain);
    else passed++;
    tick(7);
    total++;
    if (tdrain !== 1'b0 || tfill !== 1'b0)
      $display("FAIL switch_early: got td=%b tf=%b want 0/0", tdrain, tfill);
    else passed++;
    tick(1);
    total++;
    if (tdrain !== 1'b1 || tfill !== 1'b0)
      $display("FAIL switch_done: got td=%b tf=%b want 1/0", tdrain, tfill);
    else passed++;
  endtask

  task automatic test_reset_mid;
    pump = 1'b0;  // FILL
    tick(1);
    tick(5);
    total++;
    if (elapsed !== 16'd1) $display("FAIL rmid_el: got %0d want 1", elapsed);
    else passed++;
    reset = 1'b1; tick(1); reset = 1'b0;
    total++;
    if (elapsed !== 16'd0 || busy !== 1'b0)
      $display("FAIL rmid_reset: got el=%0d busy=%b want 0/0", elapsed, busy);
    else passed++;
    tick(1);
    tick(11);
    total++;
    if (tfill !== 1'b0) $display("FAIL rmid_early: got %b want 0", tfill);
    else passed++;
    tick(1);
    total++;
    if (tfill !== 1'b1) $display("FAIL rmid_done: got %b want 1", tfill);
    else passed++;
  endtask

  task automatic test_reset_wash_cnt;
    water_fill = 1'b0; motor = 1'b1; agitator = 1'b1;
    tick(1);
    tick(8);  // first wash done, now on rinse
    total++;
    if (twash !== 1'b1 || trinse !== 1'b0)
      $display("FAIL rwc_first: got tw=%b tr=%b want 1/0", twash, trinse);
    else passed++;
    reset = 1'b1; tick(1); reset = 1'b0;
    tick(1);
    tick(7);
    total++;
    if (twash !== 1'b0) $display("FAIL rwc_early: got %b want 0", twash);
    else passed++;
    tick(1);
    total++;
    if (twash !== 1'b1 || trinse !== 1'b0)
      $display("FAIL rwc_done: got tw=%b tr=%b want 1/0", twash, trinse);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_restart;
    test_restart_vs_done;
    test_wash;
    test_spin_pause;
    test_wash_after_spin;
    test_conflict;
    test_switch;
    test_reset_mid;
    test_reset_wash_cnt;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
